// File: rtl/opcodes.sv
// Shared instruction-set definitions for the fetch and control blocks.
package opcodes;

  // Instruction word field positions (MSB of each field)
  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned REG_MSB   = 11;
  localparam int unsigned IMM_MSB   = 7;

  // Field widths derived from the layout
  localparam int unsigned OPC_WIDTH = 4;
  localparam int unsigned REG_WIDTH = 4;
  localparam int unsigned IMM_WIDTH = 8;

  // Executed-instruction counter width
  localparam int unsigned CNT_WIDTH = 16;

  // Full 4-bit opcode map so any IR value casts to a named member
  typedef enum logic [3:0] {
    NOOP  = 4'h0,
    LDI   = 4'h1,
    LD    = 4'h2,
    ST    = 4'h3,
    ADD   = 4'h4,
    SUB   = 4'h5,
    ANDR  = 4'h6,
    ORR   = 4'h7,
    XORR  = 4'h8,
    SHL   = 4'h9,
    SHR   = 4'hA,
    JMP   = 4'hB,
    JZ    = 4'hC,
    JNZ   = 4'hD,
    WAIT0 = 4'hE,
    WAIT1 = 4'hF
  } opcodes_t;

  // PC update command issued by control; encoding 2'b11 is illegal
  typedef enum logic [1:0] {
    PcWait = 2'd0,
    PcInc  = 2'd1,
    PcJmp  = 2'd2
  } PcSel_t;

  // Instruction phase shared by control and fetch so they stay in lockstep
  typedef enum logic [1:0] {
    Fetch   = 2'd0,
    Read    = 2'd1,
    Execute = 2'd2
  } phase_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous level inputs (no debounce).
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      meta <= '0;
      Q    <= '0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, phase tracking,
// switch synchronisation, halt detection and executed-instruction count.
module fetch_unit
  import opcodes::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic [INSTR_WIDTH-1:0] ProgData,
  output logic [PC_WIDTH-1:0]    ProgAddr,
  input  PcSel_t                 PcSel,
  input  logic [PC_WIDTH-1:0]    JumpAddr,
  input  logic                   SwRaw,
  output logic                   Sw8,
  output opcodes_t               OpCode,
  output logic [REG_WIDTH-1:0]   RegAddr,
  output logic [IMM_WIDTH-1:0]   Imm,
  output logic [1:0]             Phase,
  output logic                   Halted,
  output logic [CNT_WIDTH-1:0]   InstrCount
);

  phase_t                 phase;
  phase_t                 phaseNext;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    pcNext;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   loadIr;
  logic                   inExecute;
  logic                   doCount;
  logic                   doHalt;

  // Phase sequencing and per-phase strobes
  always_comb begin
    phaseNext = Fetch;
    loadIr    = 1'b0;
    inExecute = 1'b0;
    case (phase)
      Fetch: begin
        phaseNext = Read;
        loadIr    = 1'b1;
      end
      Read: begin
        phaseNext = Execute;
      end
      Execute: begin
        phaseNext = Fetch;
        inExecute = 1'b1;
      end
      default: begin
        phaseNext = Fetch;
      end
    endcase
  end

  // PC follows PcSel on every edge; illegal encodings hold like PcWait
  always_comb begin
    pcNext  = pc;
    doCount = 1'b0;
    doHalt  = 1'b0;
    case (PcSel)
      PcInc: begin
        pcNext  = pc + PC_WIDTH'(1);
        doCount = inExecute;
      end
      PcJmp: begin
        pcNext  = JumpAddr;
        doCount = inExecute;
        doHalt  = inExecute && (JumpAddr == pc);
      end
      default: begin
        pcNext = pc;
      end
    endcase
  end

  // Phase state register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      phase <= Fetch;
    end else begin
      phase <= phaseNext;
    end
  end

  // Program counter
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc <= '0;
    end else begin
      pc <= pcNext;
    end
  end

  // Instruction register captures the word addressed during Fetch
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ir <= '0;
    end else if (loadIr) begin
      ir <= ProgData;
    end
  end

  // Sticky jump-to-self flag
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Halted <= 1'b0;
    end else if (doHalt) begin
      Halted <= 1'b1;
    end
  end

  // Saturating count of Execute phases that advanced or jumped
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      InstrCount <= '0;
    end else if (doCount && (InstrCount != '1)) begin
      InstrCount <= InstrCount + CNT_WIDTH'(1);
    end
  end

  sync2 #(
    .WIDTH (1)
  ) uSwSync (
    .Clock  (Clock),
    .nReset (nReset),
    .D      (SwRaw),
    .Q      (Sw8)
  );

  assign ProgAddr = pc;
  assign OpCode   = opcodes_t'(ir[OPC_MSB -: OPC_WIDTH]);
  assign RegAddr  = ir[REG_MSB -: REG_WIDTH];
  assign Imm      = ir[IMM_MSB -: IMM_WIDTH];
  assign Phase    = phase;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized PcSel/JumpAddr/SwRaw traffic checked against a behavioural model.
module tb_fetch_unit;
  import opcodes::*;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_INC  = 2'd1;
  localparam logic [1:0] S_JMP  = 2'd2;
  localparam logic [1:0] S_BAD  = 2'd3;

  logic        Clock;
  logic        nReset;
  logic [15:0] ProgData;
  logic [7:0]  ProgAddr;
  logic [1:0]  pcSelBits;
  logic [7:0]  JumpAddr;
  logic        SwRaw;
  logic        Sw8;
  opcodes_t    OpCode;
  logic [3:0]  RegAddr;
  logic [7:0]  Imm;
  logic [1:0]  Phase;
  logic        Halted;
  logic [15:0] InstrCount;

  logic [15:0] rom [256];
  assign ProgData = rom[ProgAddr];

  fetch_unit #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (16)
  ) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .ProgData   (ProgData),
    .ProgAddr   (ProgAddr),
    .PcSel      (PcSel_t'(pcSelBits)),
    .JumpAddr   (JumpAddr),
    .SwRaw      (SwRaw),
    .Sw8        (Sw8),
    .OpCode     (OpCode),
    .RegAddr    (RegAddr),
    .Imm        (Imm),
    .Phase      (Phase),
    .Halted     (Halted),
    .InstrCount (InstrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int nChecks = 0;
  int nPass   = 0;
  bit cmpEn   = 1'b0;

  // Behavioural model: instruction-level view of the fetch stage
  logic [7:0]  mpc;
  logic [15:0] mir;
  int          mphase;
  bit          mhalt;
  int          mcnt;
  bit          swHist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mpc    = 8'h00;
    mir    = 16'h0000;
    mphase = 0;
    mhalt  = 1'b0;
    mcnt   = 0;
    swHist.delete();
  endtask

  // Model advances one clock: phases cycle 0,1,2; Execute commits the instruction
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      modelReset();
    end else begin
      swHist.push_back(SwRaw);
      if (swHist.size() > 2) void'(swHist.pop_front());
      if (mphase == 0) mir = rom[mpc];
      if (mphase == 2) begin
        if (pcSelBits == S_JMP && JumpAddr == mpc) mhalt = 1'b1;
        if ((pcSelBits == S_INC || pcSelBits == S_JMP) && mcnt < 65535) mcnt = mcnt + 1;
      end
      if (pcSelBits == S_INC) mpc = mpc + 8'd1;
      else if (pcSelBits == S_JMP) mpc = JumpAddr;
      mphase = (mphase + 1) % 3;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge Clock) begin : compare
    logic expSw;
    if (cmpEn) begin
      expSw = (swHist.size() >= 2) ? swHist[0] : 1'b0;
      chk("ProgAddr",   32'(ProgAddr),      32'(mpc));
      chk("OpCode",     32'(4'(OpCode)),    32'(mir[15:12]));
      chk("RegAddr",    32'(RegAddr),       32'(mir[11:8]));
      chk("Imm",        32'(Imm),           32'(mir[7:0]));
      chk("Phase",      32'(Phase),         32'(mphase));
      chk("Halted",     32'(Halted),        32'(mhalt));
      chk("InstrCount", 32'(InstrCount),    32'(mcnt));
      chk("Sw8",        32'(Sw8),           32'(expSw));
    end
  end

  task automatic driveIdle();
    pcSelBits = ($urandom_range(0, 3) == 0) ? S_BAD : S_WAIT;
    JumpAddr  = 8'($urandom);
  endtask

  // One clock: on the falling edge drive sel/ja in Execute, idle otherwise
  task automatic step(input logic [1:0] sel, input logic [7:0] ja, output bit wasExec);
    @(negedge Clock);
    wasExec = (mphase == 2);
    if (wasExec) begin
      pcSelBits = sel;
      JumpAddr  = ja;
    end else begin
      driveIdle();
    end
  endtask

  // Run through one Execute (applying sel) until phase p is reached
  task automatic waitPhase(input int p, input logic [1:0] sel, input logic [7:0] ja);
    bit sawExec = 1'b0;
    bit e;
    int n = 0;
    do begin
      step(sel, ja, e);
      if (e) sawExec = 1'b1;
      n++;
    end while (!(sawExec && mphase == p) && n < 8);
    if (!(sawExec && mphase == p)) begin
      nChecks++;
      $display("FAIL waitPhase: reached phase %0d, required %0d", mphase, p);
    end
  endtask

  initial begin
    bit e;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h1101;
    rom[1] = 16'h2202;
    rom[2] = 16'h3303;
    pcSelBits = S_WAIT;
    JumpAddr  = 8'h00;
    SwRaw     = 1'b0;
    nReset    = 1'b0;
    modelReset();

    // Reset values
    #1;
    chk("rst ProgAddr",   32'(ProgAddr),   32'h00);
    chk("rst OpCode",     32'(4'(OpCode)), 32'h0);
    chk("rst Imm",        32'(Imm),        32'h00);
    chk("rst Phase",      32'(Phase),      32'h0);
    chk("rst InstrCount", 32'(InstrCount), 32'h0);
    cmpEn = 1'b1;
    #11 nReset = 1'b1;

    // Sequential fetch of 0x1101, 0x2202, 0x3303
    step(S_INC, 8'h00, e);
    chk("seq0 OpCode",  32'(4'(OpCode)), 32'h1);
    chk("seq0 RegAddr", 32'(RegAddr),    32'h1);
    chk("seq0 Imm",     32'(Imm),        32'h01);
    for (int k = 1; k < 3; k++) begin
      waitPhase(1, S_INC, 8'h00);
      chk("seq OpCode",  32'(4'(OpCode)), 32'(k + 1));
      chk("seq RegAddr", 32'(RegAddr),    32'(k + 1));
      chk("seq Imm",     32'(Imm),        32'(k + 1));
    end
    waitPhase(0, S_INC, 8'h00);
    chk("seq InstrCount",   32'(InstrCount), 32'd3);
    chk("seq ProgAddr",     32'(ProgAddr),   32'h03);
    chk("model InstrCount", 32'(mcnt),       32'd3);
    chk("model pc",         32'(mpc),        32'h03);

    // Wrap from 0xFF
    waitPhase(0, S_JMP, 8'hFF);
    chk("wrap pre ProgAddr", 32'(ProgAddr), 32'hFF);
    waitPhase(0, S_INC, 8'h00);
    chk("wrap ProgAddr",   32'(ProgAddr),   32'h00);
    chk("wrap InstrCount", 32'(InstrCount), 32'd5);

    // WAIT stall at 0x10
    waitPhase(0, S_JMP, 8'h10);
    for (int k = 0; k < 4; k++) begin
      waitPhase(0, S_WAIT, 8'h00);
      chk("wait ProgAddr",   32'(ProgAddr),   32'h10);
      chk("wait InstrCount", 32'(InstrCount), 32'd6);
    end
    waitPhase(0, S_INC, 8'h00);
    chk("wait release ProgAddr", 32'(ProgAddr), 32'h11);

    // Jump, then jump-to-self halts (sticky, still counted)
    waitPhase(0, S_JMP, 8'h05);
    waitPhase(0, S_JMP, 8'h40);
    chk("jmp ProgAddr", 32'(ProgAddr), 32'h40);
    chk("jmp Halted",   32'(Halted),   32'h0);
    waitPhase(0, S_JMP, 8'h40);
    chk("halt Halted",     32'(Halted),     32'h1);
    chk("halt InstrCount", 32'(InstrCount), 32'd10);
    waitPhase(0, S_JMP, 8'h40);
    chk("halt again InstrCount", 32'(InstrCount), 32'd11);
    waitPhase(0, S_INC, 8'h00);
    chk("halt sticky",     32'(Halted),   32'h1);
    chk("halt ProgAddr",   32'(ProgAddr), 32'h41);
    chk("model halt",      32'(mhalt),    32'h1);

    // Switch synchroniser latency
    SwRaw = 1'b1;
    @(posedge Clock); #1;
    chk("sw 1 edge", 32'(Sw8), 32'h0);
    @(posedge Clock); #1;
    chk("sw 2 edges", 32'(Sw8), 32'h1);
    SwRaw = 1'b0;
    waitPhase(0, S_WAIT, 8'h00);
    waitPhase(0, S_WAIT, 8'h00);
    #1 SwRaw = 1'b1;
    #2 SwRaw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clock); #1;
      chk("sw glitch", 32'(Sw8), 32'h0);
    end

    // Reset asserted mid-Execute with PC=0x23
    SwRaw = 1'b1;
    waitPhase(0, S_JMP, 8'h23);
    waitPhase(2, S_INC, 8'h00);
    chk("pre-rst ProgAddr", 32'(ProgAddr), 32'h23);
    chk("pre-rst Sw8",      32'(Sw8),      32'h1);
    #1 nReset = 1'b0;
    #1;
    chk("midrst ProgAddr",   32'(ProgAddr),   32'h00);
    chk("midrst Phase",      32'(Phase),      32'h0);
    chk("midrst Halted",     32'(Halted),     32'h0);
    chk("midrst InstrCount", 32'(InstrCount), 32'h0);
    chk("midrst Sw8",        32'(Sw8),        32'h0);
    chk("midrst RegAddr",    32'(RegAddr),    32'h0);
    @(posedge Clock);
    #2 nReset = 1'b1;
    step(S_WAIT, 8'h00, e);
    chk("post-rst ProgAddr", 32'(ProgAddr), 32'h00);
    chk("post-rst Phase",    32'(Phase),    32'h0);
    step(S_WAIT, 8'h00, e);
    chk("post-rst OpCode",  32'(4'(OpCode)), 32'h1);
    chk("post-rst Imm",     32'(Imm),        32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0] sel;
      logic [7:0] ja;
      sel = 2'($urandom_range(0, 3));
      ja  = ($urandom_range(0, 3) == 0) ? mpc : 8'($urandom);
      if ($urandom_range(0, 3) == 0) SwRaw = ~SwRaw;
      waitPhase(0, sel, ja);
      if (i == 300) begin
        #2 nReset = 1'b0;
        @(posedge Clock);
        #2 nReset = 1'b1;
      end
    end

    @(negedge Clock);
    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `control`. It holds the program counter, addresses program memory, and captures each instruction into an instruction register. It presents the opcode, register address and immediate fields to `control` and the datapath, and applies the `PcSel` decision that `control` issues in its Execute phase. It also synchronises the raw switch used by the WAIT0/WAIT1 opcodes, and provides halt detection and an executed-instruction count for debug.

## Interface
- `PC_WIDTH`, 8: program counter and program memory address width.
- `INSTR_WIDTH`, 16: instruction word width; fixed field layout below.
- `Clock` in 1: single system clock, rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `ProgData` in `INSTR_WIDTH`: program memory read data; combinational from `ProgAddr`.
- `ProgAddr` out `PC_WIDTH`: program memory address; equals PC.
- `PcSel` in `opcodes::PcSel_t`: PC update command from `control` (`PcWait`, `PcInc`, `PcJmp`).
- `JumpAddr` in `PC_WIDTH`: jump target from the datapath ALU result.
- `SwRaw` in 1: asynchronous switch input.
- `Sw8` out 1: synchronised switch, fed to `control`.
- `OpCode` out `opcodes::opcodes_t`: IR[15:12].
- `RegAddr` out 4: IR[11:8].
- `Imm` out 8: IR[7:0].
- `Phase` out 2: fetch-side phase (Fetch/Read/Execute); for debug and bench alignment.
- `Halted` out 1: a jump-to-self has been executed.
- `InstrCount` out 16: count of completed Execute phases that advanced or jumped.

## Operation
- **Phase FSM** mirrors `control`: Fetch→Read→Execute→Fetch, one clock each. Reset enters Fetch, so both FSMs stay in lockstep from reset release.
- **IR load**: on the rising edge ending Fetch, IR ← `ProgData`. IR holds through Read and Execute. `OpCode`/`RegAddr`/`Imm` are driven combinationally from IR.
- **PC update**: applied on every edge according to `PcSel`, regardless of `Phase`. `control` drives `PcWait` outside Execute, so the PC effectively changes only on the edge ending Execute.
  - `PcWait`: hold.
  - `PcInc`: PC+1, modulo 2^`PC_WIDTH` (0xFF→0x00 with the defaults).
  - `PcJmp`: PC ← `JumpAddr`.
- **WAIT looping**: `PcWait` in Execute keeps the PC unchanged. The next Fetch re-reads the same word, so the WAIT instruction re-executes every 3 cycles.
- **Sw8**: two-flop synchroniser on `SwRaw`, no debounce.
- **Halted**: set on the edge ending Execute when `PcSel==PcJmp` and `JumpAddr==PC`. It is sticky until reset. The PC keeps its normal behaviour; `Halted` is a flag only.
- **InstrCount**: increments on the edge ending Execute when `PcSel` is `PcInc` or `PcJmp`. It saturates at 0xFFFF; it does not count WAIT stalls.
- **Illegal `PcSel` encoding**: treated as `PcWait`.

## Timing
- **Reset values** (asynchronous, immediate): PC=0, `ProgAddr`=0, IR=0 (so `OpCode`=NOOP encoding 0, `RegAddr`=0, `Imm`=0), `Phase`=Fetch, both sync flops 0 so `Sw8`=0, `Halted`=0, `InstrCount`=0.
- **Reset asserted mid-cycle** (any phase): all state returns to the values above. The first Fetch after release reads address 0.
- **Fetch latency**: `ProgAddr` is valid throughout Fetch. The IR is valid from the first cycle of Read, i.e. one cycle after Fetch.
- **Instruction period**: 3 cycles. PC N+1 appears on `ProgAddr` at the start of the following Fetch.
- **`SwRaw`→`Sw8` latency**: 2 rising edges.
- **Simultaneous events**:
  - A jump to self with an already-set `Halted` leaves `Halted` at 1 and still counts.
  - `PcInc` at PC=max wraps to 0 and counts.

## Structure
- `PcSel_t`, `opcodes_t` and the field positions (`OPC_MSB`=15, `REG_MSB`=11, `IMM_MSB`=7) live in the `opcodes` package.
- Move the phase enum currently local to `control` into `opcodes` as `phase_t`, so both blocks share it.
- One sub-module, `sync2`: a generic two-flop synchroniser with the same clock/reset ports, reusable for other switch inputs.

## Test plan
- **Reset and first fetch**: assert `nReset` low mid-Execute with PC=0x23. Expect all outputs at reset values immediately. After release, expect `ProgAddr`=0x00 in Fetch and IR=`ProgData`@0 in Read.
- **Sequential fetch**: ROM words 0x1101, 0x2202, 0x3303 at 0–2 with `PcSel`=`PcInc` in Execute.
  - Expect `OpCode`/`RegAddr`/`Imm` = 1/1/0x01, then 2/2/0x02, then 3/3/0x03, each valid from Read.
  - Expect `InstrCount`=3 after 9 cycles.
- **Wrap**: PC=0xFF with `PcInc` → PC=0x00 after the Execute edge; `InstrCount` increments.
- **WAIT stall**: `PcWait` held for 4 instruction periods at PC=0x10.
  - Expect `ProgAddr`=0x10 throughout and `InstrCount` unchanged.
  - After `PcInc`, expect PC=0x11.
- **Jump and halt**:
  - `PcJmp` with `JumpAddr`=0x40 from PC=0x05 → PC=0x40, `Halted`=0.
  - `PcJmp` with `JumpAddr`=0x40 at PC=0x40 → `Halted`=1, sticky until reset.
- **Switch sync**: toggle `SwRaw` 0→1 → `Sw8`=1 exactly 2 edges later. A 1-cycle glitch on `SwRaw` sampled between edges is not passed to `Sw8`.
